// File: rtl/mavg_pkg.sv
// Shared constants, mode encoding and width helper for the moving-average filter.
package mavg_pkg;

    localparam int unsigned DEF_DATA_W     = 2;
    localparam int unsigned DEF_NUM_CH     = 3;
    localparam int unsigned DEF_LOG2_DEPTH = 2;

    typedef enum logic {
        MODE_SUM  = 1'b0,
        MODE_MEAN = 1'b1
    } mode_e;

    // Accumulator width that holds DEPTH full-scale samples without wrapping.
    function automatic int unsigned acc_w(input int unsigned data_w,
                                          input int unsigned log2_depth);
        return data_w + log2_depth;
    endfunction

endpackage

// File: rtl/mavg_channel.sv
// One channel of the moving-average filter: zero-prefilled circular buffer
// plus a running window sum, indexed by the shared write pointer.
module mavg_channel
    import mavg_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned LOG2_DEPTH = DEF_LOG2_DEPTH
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     clear,
    input  logic                                     in_valid,
    input  logic [LOG2_DEPTH-1:0]                    wptr,
    input  logic [DATA_W-1:0]                        sample,
    output logic [acc_w(DATA_W, LOG2_DEPTH)-1:0]     sum_nxt
);

    localparam int unsigned ACC_W = acc_w(DATA_W, LOG2_DEPTH);
    localparam int unsigned DEPTH = 2 ** LOG2_DEPTH;

    logic [DATA_W-1:0] buf_q [DEPTH];
    logic [ACC_W-1:0]  sum_q;

    // The overwritten entry is the oldest sample, or zero during warm-up.
    always_comb begin
        sum_nxt = sum_q + ACC_W'(sample) - ACC_W'(buf_q[wptr]);
    end

    always_ff @(posedge clk) begin
        if (rst_n || clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            sum_q <= '0;
        end else if (in_valid) begin
            buf_q[wptr] <= sample;
            sum_q       <= sum_nxt;
        end
    end

endmodule

// File: rtl/moving_avg_filter.sv
// Multi-channel moving-average filter: per-channel window sum or mean,
// registered with a one-cycle valid strobe and a combinational output gate.
module moving_avg_filter
    import mavg_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned LOG2_DEPTH = DEF_LOG2_DEPTH
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          clear,
    input  logic                                          in_valid,
    input  logic [NUM_CH*DATA_W-1:0]                      in_data,
    input  logic                                          mode,
    input  logic                                          out_en,
    output logic                                          out_valid,
    output logic [NUM_CH*acc_w(DATA_W, LOG2_DEPTH)-1:0]   out_data,
    output logic                                          out_full,
    output logic [LOG2_DEPTH:0]                           count
);

    localparam int unsigned ACC_W = acc_w(DATA_W, LOG2_DEPTH);
    localparam logic [LOG2_DEPTH:0] DEPTH_CNT = (LOG2_DEPTH+1)'(1) << LOG2_DEPTH;

    logic [LOG2_DEPTH-1:0]      wptr_q;
    logic [LOG2_DEPTH:0]        count_q;
    logic                       out_valid_q;
    logic [NUM_CH*ACC_W-1:0]    out_data_q;
    logic [NUM_CH*ACC_W-1:0]    result;
    logic                       mean_sel;

    assign mean_sel = (mode_e'(mode) == MODE_MEAN);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [ACC_W-1:0] sum_nxt;

        mavg_channel #(
            .DATA_W    (DATA_W),
            .LOG2_DEPTH(LOG2_DEPTH)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .clear   (clear),
            .in_valid(in_valid),
            .wptr    (wptr_q),
            .sample  (in_data[c*DATA_W +: DATA_W]),
            .sum_nxt (sum_nxt)
        );

        // Mean always divides by DEPTH, so empty warm-up slots count as zero.
        assign result[c*ACC_W +: ACC_W] = mean_sel ? (sum_nxt >> LOG2_DEPTH) : sum_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst_n || clear) begin
            wptr_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                wptr_q     <= wptr_q + LOG2_DEPTH'(1);
                out_data_q <= result;
                if (count_q != DEPTH_CNT) begin
                    count_q <= count_q + (LOG2_DEPTH+1)'(1);
                end
            end
        end
    end

    assign out_valid = out_en & out_valid_q;
    assign out_data  = out_en ? out_data_q : '0;
    assign out_full  = (count_q == DEPTH_CNT);
    assign count     = count_q;

endmodule

// File: doc/moving_avg_filter.md
# moving_avg_filter

Parametrised multi-channel moving-average filter. Accepts one packed sample vector per `in_valid` cycle, keeps a sliding window of the last `DEPTH` samples per channel, and emits the registered window sum or window mean per channel. It generalises the fixed 3-channel, 2-bit, 4-deep averager to arbitrary width, depth and channel count. It adds overflow-free accumulators, a valid strobe, a flush and a selectable sum/mean output.

## Interface

Parameters:
- `DATA_W`, 2 — bits per channel sample, unsigned.
- `NUM_CH`, 3 — number of independent channels.
- `LOG2_DEPTH`, 2 — window depth is `DEPTH = 2**LOG2_DEPTH`; legal range 1..8.

Derived width: `ACC_W = DATA_W + LOG2_DEPTH`.

Ports:
- `clk` — in, 1 — single clock; all state updates on the rising edge.
- `rst_n` — in, 1 — synchronous, active-high reset. The name follows codebase convention; the polarity is high = reset.
- `clear` — in, 1 — synchronous flush of the window, same effect as reset.
- `in_valid` — in, 1 — `in_data` is accepted this cycle. There is no backpressure.
- `in_data` — in, `NUM_CH*DATA_W` — channel c occupies bits `[c*DATA_W +: DATA_W]`.
- `mode` — in, 1 — 0 = output the window sum; 1 = output the window mean.
- `out_en` — in, 1 — output gate; when low, `out_data` and `out_valid` read 0.
- `out_valid` — out, 1 — one-cycle strobe marking a new result.
- `out_data` — out, `NUM_CH*ACC_W` — channel c occupies bits `[c*ACC_W +: ACC_W]`.
- `out_full` — out, 1 — the window holds `DEPTH` real samples.
- `count` — out, `LOG2_DEPTH+1` — number of samples in the window, saturating at `DEPTH`.

## Operation

- Per channel state:
  - a circular buffer of `DEPTH` x `DATA_W` entries, all zero after reset or clear;
  - a shared write pointer `wptr` of `LOG2_DEPTH` bits, which wraps from `DEPTH-1` to 0 naturally;
  - an accumulator `sum` of `ACC_W` bits.
- On an accepted sample (`in_valid`=1, `clear`=0, `rst_n`=0), for each channel c:
  - `sum_c <= sum_c + new_c - buf_c[wptr]`;
  - `buf_c[wptr] <= new_c`;
  - `wptr <= wptr + 1`;
  - `count <= min(count+1, DEPTH)`.
- Arithmetic is exact: `sum` never exceeds `DEPTH*(2**DATA_W-1)`, so `ACC_W` never wraps. The subtrahend is the value being overwritten. Because the buffer is zero-prefilled, the subtraction is valid during warm-up.
- Mean = `sum >> LOG2_DEPTH`, floor-truncated, zero-extended to `ACC_W`.
  - During warm-up the divisor is still `DEPTH`, so empty slots count as zero.
  - `mode` is applied at the output register. It is sampled on the same edge as the sample and can change any cycle.
- Output register: on an accepted sample, the `out_data` register loads the post-update sums (or means) and `out_valid` is set to 1. Otherwise `out_valid` is 0 and `out_data` holds its value.
- `out_en` gating is combinational on the registered values. Internal state keeps updating while the gate is low.
- `out_full` = (`count == DEPTH`).
- Priority: `rst_n` > `clear` > `in_valid`.
  - With `clear` and `in_valid` in the same cycle, the sample is dropped.
  - `clear` zeroes the buffers, sums, `wptr`, `count`, `out_data` and `out_valid`.
- Reset values: `out_valid`=0, `out_data`=0, `out_full`=0, `count`=0.

## Timing

- Latency is 1 cycle: a sample with `in_valid` high in cycle n appears in `out_data`, with `out_valid`=1, in cycle n+1.
- Throughput is one sample per cycle. Back-to-back `in_valid` produces back-to-back `out_valid`.
- `count` and `out_full` update on the same edge as `out_data`, so they are consistent in cycle n+1.
- Gaps in `in_valid` freeze all state. `out_data` holds its value and `out_valid` is 0.
- Reset or clear asserted mid-stream: the next cycle shows all outputs at 0. The first sample afterwards starts a fresh window with `count`=1.

## Structure

- Package `mavg_pkg` holds:
  - the `acc_w(data_w, log2_depth)` function;
  - the `MODE_SUM`/`MODE_MEAN` constants;
  - the default parameter constants.
- Sub-module `mavg_channel`: one channel's buffer and accumulator, instantiated `NUM_CH` times with a generate loop, all driven by the shared `wptr`.
- The top level owns `wptr`, `count`, the output register, mode selection and gating.

## Test plan

Defaults unless noted: `DATA_W`=2, `NUM_CH`=3, `DEPTH`=4.

- Reset: assert `rst_n` for 2 cycles with `in_valid`=1 → `out_data`=0, `out_valid`=0, `count`=0, `out_full`=0. The first sample after release gives `count`=1.
- Warm-up, sum mode: feed ch0=3, ch1=1, ch2=0 for 4 cycles →
  - ch0 sums 3, 6, 9, 12;
  - ch1 sums 1, 2, 3, 4;
  - ch2 stays 0;
  - `out_full` rises with the 4th result.
- Wrap and mean mode: continue the previous scenario with ch0=0 for 4 cycles, `mode`=1 → ch0 sums 9, 6, 3, 0, shown as means 2, 1, 0, 0. Also check `mode`=1 during warm-up on 3, 3 → mean 1.
- Gaps: insert 3 idle cycles mid-stream → `out_valid`=0 and `out_data` held. The next sample continues from the held sum with no loss.
- Clear collision: `clear` and `in_valid` with ch0=2 in the same cycle → all outputs 0, sample dropped. Next ch0=2 → sum 2, `count`=1.
- Gate and max parameters: `out_en`=0 for 2 samples → `out_data`=0 and `out_valid`=0. Re-enable → current sums reflect both samples. With `DATA_W`=8, `LOG2_DEPTH`=3, feed all-255 → sum reaches 2040, with no overflow.
